// File: rtl/axi_led_pwm_slave.sv
// axi_led_pwm_slave: AXI4-Lite slave with four 32-bit registers driving an
// 8-bit LED bank through a PWM dimmer and an optional blinker.
// Build option: define LED_BLINK_EN to synthesise the blink counter; without it
// the blink gate is tied open and CTRL[9]/BLINK_DIV are plain storage.
module axi_led_pwm_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32
) (
  input  logic                              s_axi_aclk,
  input  logic                              s_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                        s_axi_awprot,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  output logic [1:0]                        s_axi_bresp,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                        s_axi_arprot,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                        s_axi_rresp,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output logic [7:0]                        led
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_DUTY   = 2'd1,
    REG_BLINK  = 2'd2,
    REG_STATUS = 2'd3
  } reg_sel_t;

  // Handshake / channel state
  logic                          ready_en;
  logic                          aw_held;
  logic                          w_held;
  reg_sel_t                      aw_sel;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]             wstrb_q;
  logic                          bvalid_q;
  logic [1:0]                    bresp_q;
  logic                          ar_pend;
  reg_sel_t                      ar_sel;
  logic                          rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

  // Register file
  logic [7:0]  pattern;
  logic        pwm_en;
  logic        blink_en;
  logic [7:0]  duty;
  logic [31:0] blink_div;
  logic [15:0] write_cnt;

  // LED datapath
  logic [7:0]  pwm_cnt;
  logic        pwm_on;
  logic        blink_gate;
  logic [7:0]  led_q;

  logic        commit;
  logic [31:0] rd_mux;
  logic        unused_inputs;

  assign commit = aw_held && w_held;

  // Readies stay low during reset and for the first edge after it so that every
  // output reads 0 while reset is asserted.
  assign s_axi_awready = ready_en && !aw_held && !bvalid_q;
  assign s_axi_wready  = ready_en && !w_held && !bvalid_q;
  // ar_pend also blocks arready so a second AR cannot overwrite the captured
  // address in the cycle before rvalid rises.
  assign s_axi_arready = ready_en && !rvalid_q && !ar_pend;

  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = '0;
  assign led          = led_q;

  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot,
                           s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:4], s_axi_awaddr[1:0],
                           s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:4], s_axi_araddr[1:0]};

  // Ready enable: rises on the first edge after reset deasserts
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Write address/data capture, commit and B response
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_sel    <= REG_CTRL;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      write_cnt <= '0;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        aw_held <= 1'b1;
        aw_sel  <= reg_sel_t'(s_axi_awaddr[3:2]);
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (commit) begin
        aw_held   <= 1'b0;
        w_held    <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= (aw_sel == REG_STATUS) ? 2'b10 : 2'b00;
        write_cnt <= write_cnt + 16'd1;
      end else if (bvalid_q && s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Register file update on commit, byte lane by byte lane
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      pattern   <= '0;
      pwm_en    <= 1'b0;
      blink_en  <= 1'b0;
      duty      <= '0;
      blink_div <= '0;
    end else if (commit) begin
      case (aw_sel)
        REG_CTRL: begin
          if (wstrb_q[0]) pattern <= wdata_q[7:0];
          if (wstrb_q[1]) begin
            pwm_en   <= wdata_q[8];
            blink_en <= wdata_q[9];
          end
        end
        REG_DUTY: begin
          if (wstrb_q[0]) duty <= wdata_q[7:0];
        end
        REG_BLINK: begin
          for (int unsigned i = 0; i < 4; i++) begin
            if (wstrb_q[i]) blink_div[8*i +: 8] <= wdata_q[8*i +: 8];
          end
        end
        default: ;
      endcase
    end
  end

  // Read data selection from the captured read address
  always_comb begin
    rd_mux = '0;
    case (ar_sel)
      REG_CTRL:   rd_mux = {22'd0, blink_en, pwm_en, pattern};
      REG_DUTY:   rd_mux = {24'd0, duty};
      REG_BLINK:  rd_mux = blink_div;
      REG_STATUS: rd_mux = {write_cnt, 8'd0, led_q};
      default:    rd_mux = '0;
    endcase
  end

  // Read channel: capture address, load data the edge after, hold until rready
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      ar_pend  <= 1'b0;
      ar_sel   <= REG_CTRL;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (s_axi_arvalid && s_axi_arready) begin
        ar_pend <= 1'b1;
        ar_sel  <= reg_sel_t'(s_axi_araddr[3:2]);
      end
      // Loads from the current (pre-commit) register values on a shared edge.
      if (ar_pend) begin
        ar_pend  <= 1'b0;
        rdata_q  <= rd_mux;
        rvalid_q <= 1'b1;
      end else if (rvalid_q && s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

`ifdef LED_BLINK_EN
  logic [31:0] blink_cnt;
  logic        blink_phase;
  logic        blink_div_wr;

  assign blink_div_wr = commit && (aw_sel == REG_BLINK);

  // Blink timebase: toggles phase every BLINK_DIV clocks, restarts on a divider write
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_div_wr) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_div != '0) begin
      if (blink_cnt >= blink_div - 32'd1) begin
        blink_cnt   <= '0;
        blink_phase <= !blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 32'd1;
      end
    end
  end

  assign blink_gate = !blink_en || blink_phase || (blink_div == '0);
`else
  assign blink_gate = 1'b1;
`endif

  assign pwm_on = (pwm_cnt < duty);

  // PWM counter and registered LED drive
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      pwm_cnt <= '0;
      led_q   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      led_q   <= pattern & {8{!pwm_en || pwm_on}} & {8{blink_gate}};
    end
  end

endmodule

// File: tb/tb_axi_led_pwm_slave.sv
// tb_axi_led_pwm_slave: directed self-checking bench for axi_led_pwm_slave.
// Blink-timing vectors are compiled in only when LED_BLINK_EN is defined.
module tb_axi_led_pwm_slave;

  logic        clk;
  logic        rst_n;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [7:0]  led;

  int n_checks = 0;
  int n_errors = 0;

  axi_led_pwm_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(32)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .s_axi_awaddr (awaddr),
    .s_axi_awprot (awprot),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata  (wdata),
    .s_axi_wstrb  (wstrb),
    .s_axi_wvalid (wvalid),
    .s_axi_wready (wready),
    .s_axi_bresp  (bresp),
    .s_axi_bvalid (bvalid),
    .s_axi_bready (bready),
    .s_axi_araddr (araddr),
    .s_axi_arprot (arprot),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata  (rdata),
    .s_axi_rresp  (rresp),
    .s_axi_rvalid (rvalid),
    .s_axi_rready (rready),
    .led          (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents AW and W together; returns at posedge+1 after both handshakes.
  task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    logic aw_done;
    logic w_done;
    int   cyc;
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc     = 0;
    while (!(aw_done && w_done) && cyc < 20) begin
      @(negedge clk);
      if (awvalid && awready) aw_done = 1'b1;
      if (wvalid && wready)   w_done  = 1'b1;
      @(posedge clk); #1;
      if (aw_done) awvalid = 1'b0;
      if (w_done)  wvalid  = 1'b0;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("aw_w_handshake", {30'd0, aw_done, w_done}, 32'h3);
  endtask

  task automatic wait_b(output logic [1:0] resp);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!bvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("b_wait", {31'd0, bvalid}, 32'h1);
    resp   = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_write(input string tag, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
    logic [1:0] resp;
    send_aw_w(addr, data, strb);
    wait_b(resp);
    check(tag, {30'd0, resp}, 32'h0);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
    int cyc;
    araddr  = addr;
    arvalid = 1'b1;
    cyc     = 0;
    @(negedge clk);
    while (!arready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("ar_wait", {31'd0, arready}, 32'h1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    cyc     = 0;
    @(negedge clk);
    while (!rvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("r_wait", {31'd0, rvalid}, 32'h1);
    data   = rdata;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] data;
    axi_read(addr, data);
    check(tag, data, exp);
  endtask

  // Counts LED-full samples over one PWM period; anything not 00/FF is stray.
  task automatic pwm_window(input string tag, input int exp_on);
    int on_cnt;
    int bad_cnt;
    on_cnt  = 0;
    bad_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (led == 8'hFF)      on_cnt++;
      else if (led != 8'h00) bad_cnt++;
    end
    check(tag, on_cnt, exp_on);
    check({tag, "_stray"}, bad_cnt, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] resp;
    rst_n   = 1'b0;
    awaddr  = '0;
    awprot  = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    araddr  = '0;
    arprot  = '0;
    arvalid = 1'b0;
    rready  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_readys", {29'd0, awready, wready, arready}, 32'h0);
    check("rst_valids", {30'd0, bvalid, rvalid}, 32'h0);
    check("rst_led", {24'd0, led}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_resps", {28'd0, bresp, rresp}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: AW and W together, CTRL <- A5
    awaddr = 32'h0; wdata = 32'h0000_00A5; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    check("t1_readys", {30'd0, awready, wready}, 32'h3);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("t1_bvalid_pre", {31'd0, bvalid}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_bvalid", {31'd0, bvalid}, 32'h1);
    check("t1_bresp", {30'd0, bresp}, 32'h0);
    @(posedge clk); #1;
    bready = 1'b1;
    @(negedge clk);
    check("t1_led", {24'd0, led}, 32'hA5);
    check("t1_bvalid_hold", {31'd0, bvalid}, 32'h1);
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    check("t1_bvalid_clr", {31'd0, bvalid}, 32'h0);
    check("t1_awready_back", {31'd0, awready}, 32'h1);
    @(posedge clk); #1;
    read_check("t1_ctrl", 32'h0, 32'h0000_00A5);
    read_check("t1_status", 32'hC, 32'h0001_00A5);

    // T2: W five clocks ahead of AW, DUTY <- 0x80
    wdata = 32'h0000_0080; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    check("t2_wready", {31'd0, wready}, 32'h1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("t2_w_held", {30'd0, wready, bvalid}, 32'h0);
      @(posedge clk); #1;
    end
    awaddr = 32'h4; awvalid = 1'b1;
    @(negedge clk);
    check("t2_awready", {31'd0, awready}, 32'h1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    check("t2_bvalid_pre", {31'd0, bvalid}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t2_bvalid", {31'd0, bvalid}, 32'h1);
    check("t2_bresp", {30'd0, bresp}, 32'h0);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    read_check("t2_duty", 32'h4, 32'h0000_0080);

    // T3: byte-lane write into BLINK_DIV; upper address bits alias
    axi_write("t3_clear_bresp", 32'h8, 32'h0000_0000, 4'hF);
    axi_write("t3_lane_bresp", 32'h8, 32'h1234_5678, 4'b0010);
    read_check("t3_blink_div", 32'h8, 32'h0000_5600);
    read_check("t3_alias", 32'h0000_1008, 32'h0000_5600);

    // T4: write to STATUS with bready held low for 4 clocks
    send_aw_w(32'hC, 32'hDEAD_BEEF, 4'hF);
    @(posedge clk); #1;
    repeat (4) begin
      @(negedge clk);
      check("t4_bvalid", {31'd0, bvalid}, 32'h1);
      check("t4_bresp", {30'd0, bresp}, 32'h2);
      check("t4_readys_low", {30'd0, awready, wready}, 32'h0);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    check("t4_bvalid_clr", {31'd0, bvalid}, 32'h0);
    check("t4_readys_back", {30'd0, awready, wready}, 32'h3);
    @(posedge clk); #1;
    read_check("t4_status", 32'hC, 32'h0005_00A5);

    // Read capturing on the commit edge returns the pre-write DUTY
    awaddr = 32'h4; wdata = 32'h0000_0011; wstrb = 4'hF; araddr = 32'h4;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    check("coll_readys", {29'd0, awready, wready, arready}, 32'h7);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("coll_rvalid_pre", {31'd0, rvalid}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("coll_valids", {30'd0, rvalid, bvalid}, 32'h3);
    check("coll_rdata_old", rdata, 32'h0000_0080);
    rready = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0; bready = 1'b0;
    read_check("coll_duty_new", 32'h4, 32'h0000_0011);

    // T5: PWM duty windows
    axi_write("t5_duty_bresp", 32'h4, 32'h0000_0040, 4'hF);
    axi_write("t5_ctrl_bresp", 32'h0, 32'h0000_01FF, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    pwm_window("t5_duty40_on", 64);
    axi_write("t5_duty0_bresp", 32'h4, 32'h0000_0000, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    pwm_window("t5_duty00_on", 0);
    axi_write("t5_dutyff_bresp", 32'h4, 32'h0000_00FF, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    pwm_window("t5_dutyff_on", 255);

`ifdef LED_BLINK_EN
    // T6: blink every 10 clocks
    begin
      logic [7:0] prev;
      int run;
      int seen;
      int bad;
      axi_write("t6_div_bresp", 32'h8, 32'h0000_000A, 4'hF);
      axi_write("t6_ctrl_bresp", 32'h0, 32'h0000_02FF, 4'hF);
      prev = led;
      run  = 0;
      seen = 0;
      bad  = 0;
      for (int i = 0; i < 80 && seen < 4; i++) begin
        @(negedge clk);
        if (led != 8'h00 && led != 8'hFF) bad++;
        if (led != prev) begin
          if (seen > 0) check("t6_run_len", run, 10);
          seen++;
          run  = 1;
          prev = led;
        end else begin
          run++;
        end
      end
      check("t6_transitions", seen, 4);
      check("t6_stray", bad, 0);
      @(posedge clk); #1;
    end
`endif

    // Reset in the middle of live B and R responses
    axi_write("rst_ctrl_bresp", 32'h0, 32'h0000_00FF, 4'hF);
    send_aw_w(32'hC, 32'h0, 4'hF);
    araddr = 32'h0; arvalid = 1'b1;
    @(negedge clk);
    check("rst_pre_arready", {31'd0, arready}, 32'h1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_pre_valids", {30'd0, bvalid, rvalid}, 32'h3);
    check("rst_pre_bresp", {30'd0, bresp}, 32'h2);
    check("rst_pre_led", {24'd0, led}, 32'hFF);
    check("rst_pre_rdata", rdata, 32'h0000_00FF);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("abort_valids", {30'd0, bvalid, rvalid}, 32'h0);
    check("abort_readys", {29'd0, awready, wready, arready}, 32'h0);
    check("abort_led", {24'd0, led}, 32'h0);
    check("abort_rdata", rdata, 32'h0);
    check("abort_bresp", {30'd0, bresp}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    read_check("abort_ctrl", 32'h0, 32'h0);
    read_check("abort_status", 32'hC, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
